// File: rtl/icache_if.sv
// Fetcher, memory-controller and flush signals of the instruction cache.
// The slave modport is the cache's view; master is the pipeline/memory side.
interface icache_if;
   logic        rob_rollback_in;
   logic        fet_request_in;
   logic [31:0] fet_address_in;
   logic        fet_ready_out;
   logic [31:0] fet_instruction_out;
   logic        mc_request_out;
   logic [31:0] mc_address_out;
   logic        mc_ready_in;
   logic [31:0] mc_instruction_in;

   modport slave (
      input  rob_rollback_in, fet_request_in, fet_address_in,
             mc_ready_in, mc_instruction_in,
      output fet_ready_out, fet_instruction_out, mc_request_out, mc_address_out
   );

   modport master (
      output rob_rollback_in, fet_request_in, fet_address_in,
             mc_ready_in, mc_instruction_in,
      input  fet_ready_out, fet_instruction_out, mc_request_out, mc_address_out
   );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per line, single refill
// outstanding. Only valid bits are reset; flushes leave cached contents intact.
module icache #(
   parameter int INDEX_BITS = 6,
   parameter int TAG_BITS   = 30 - INDEX_BITS
) (
   input logic      clk,
   input logic      rst,
   icache_if.slave  bus
);
   localparam int LINES = 1 << INDEX_BITS;

   typedef enum logic {IDLE, MISS} state_e;

   state_e              state_q, state_d;
   logic [LINES-1:0]    valid_q, valid_d;
   logic [TAG_BITS-1:0] tag_q  [LINES];
   logic [31:0]         data_q [LINES];

   logic        fet_ready_q, fet_ready_d;
   logic [31:0] fet_instr_q, fet_instr_d;
   logic        mc_req_q, mc_req_d;
   logic [31:0] mc_addr_q, mc_addr_d;
   logic        fill_we;

   logic [INDEX_BITS-1:0] req_idx, fill_idx;
   logic [TAG_BITS-1:0]   req_tag, fill_tag;
   logic                  hit;

   // The latched miss address doubles as the refill target.
   assign req_idx  = bus.fet_address_in[INDEX_BITS+1:2];
   assign req_tag  = bus.fet_address_in[31:INDEX_BITS+2];
   assign fill_idx = mc_addr_q[INDEX_BITS+1:2];
   assign fill_tag = mc_addr_q[31:INDEX_BITS+2];
   assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      fet_ready_d = 1'b0;
      fet_instr_d = fet_instr_q;
      mc_req_d    = 1'b0;
      mc_addr_d   = mc_addr_q;
      fill_we     = 1'b0;
      if (rst || bus.rob_rollback_in) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (bus.fet_request_in) begin
               if (hit) begin
                  fet_ready_d = 1'b1;
                  fet_instr_d = data_q[req_idx];
               end else begin
                  mc_req_d  = 1'b1;
                  mc_addr_d = {bus.fet_address_in[31:2], 2'b00};
                  state_d   = MISS;
               end
            end
            MISS: if (bus.mc_ready_in) begin
               fill_we           = 1'b1;
               valid_d[fill_idx] = 1'b1;
               fet_ready_d       = 1'b1;
               fet_instr_d       = bus.mc_instruction_in;
               state_d           = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         valid_q     <= '0;
         fet_ready_q <= 1'b0;
         fet_instr_q <= '0;
         mc_req_q    <= 1'b0;
         mc_addr_q   <= '0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         fet_ready_q <= fet_ready_d;
         fet_instr_q <= fet_instr_d;
         mc_req_q    <= mc_req_d;
         mc_addr_q   <= mc_addr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (fill_we) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= bus.mc_instruction_in;
      end
   end

   assign bus.fet_ready_out       = fet_ready_q;
   assign bus.fet_instruction_out = fet_instr_q;
   assign bus.mc_request_out      = mc_req_q;
   assign bus.mc_address_out      = mc_addr_q;
endmodule

// File: tb/tb_icache.sv
// Bench for icache: table of fetches plus hand-written flush/reset sequences;
// expected fetch returns and refill requests are queued and checked by monitors.
module tb_icache;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   icache_if bus ();
   icache dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;
   logic [31:0] fet_q [$];
   logic [31:0] mc_q  [$];

   typedef struct {
      logic [31:0] addr;
      bit          hit;
      logic [31:0] data;   // fill word on a miss, expected word on a hit
      bit          poke;   // pulse a second request while the miss is pending
   } vec_t;
   vec_t vec [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitors, sampling on the falling edge.
   always @(negedge clk) begin
      if (bus.fet_ready_out) begin
         if (fet_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL fet_unexpected: got %h expected no fet_ready_out", bus.fet_instruction_out);
         end else chk("fet_data", bus.fet_instruction_out, fet_q.pop_front());
      end
      if (bus.mc_request_out) begin
         if (mc_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL mc_unexpected: got %h expected no mc_request_out", bus.mc_address_out);
         end else chk("mc_addr", bus.mc_address_out, mc_q.pop_front());
      end
   end

   // Issue a fetch; on a miss, check the refill request and leave it pending.
   task automatic fetch_start(input logic [31:0] a, input bit exp_hit, input logic [31:0] exp_data);
      if (exp_hit) fet_q.push_back(exp_data);
      else         mc_q.push_back({a[31:2], 2'b00});
      bus.fet_request_in = 1'b1;
      bus.fet_address_in = a;
      step();
      bus.fet_request_in = 1'b0;
      chk("ready_lat", bus.fet_ready_out, exp_hit);
      chk("mcreq_lat", bus.mc_request_out, !exp_hit);
      step();
      chk("ready_pulse", bus.fet_ready_out, 0);
      chk("mcreq_pulse", bus.mc_request_out, 0);
   endtask

   task automatic fill(input logic [31:0] d, input bit poke);
      if (poke) begin
         bus.fet_request_in = 1'b1;
         bus.fet_address_in = 32'h10;
         step();
         bus.fet_request_in = 1'b0;
         chk("poke_ignored", bus.fet_ready_out, 0);
      end
      step();
      fet_q.push_back(d);
      bus.mc_ready_in       = 1'b1;
      bus.mc_instruction_in = d;
      step();
      bus.mc_ready_in = 1'b0;
      chk("fill_lat", bus.fet_ready_out, 1);
      step();
      chk("fill_pulse", bus.fet_ready_out, 0);
   endtask

   task automatic fetch(input logic [31:0] a, input bit exp_hit, input logic [31:0] d, input bit poke);
      fetch_start(a, exp_hit, d);
      if (!exp_hit) fill(d, poke);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_ready", bus.fet_ready_out, 0);
      chk("rst_instr", bus.fet_instruction_out, 0);
      chk("rst_mcreq", bus.mc_request_out, 0);
      chk("rst_mcaddr", bus.mc_address_out, 0);
   endtask

   initial begin
      vec[0] = '{32'h0000_0010, 1'b0, 32'h0000_0513, 1'b0};
      vec[1] = '{32'h0000_0010, 1'b1, 32'h0000_0513, 1'b0};
      vec[2] = '{32'h0000_0110, 1'b0, 32'hDEAD_BEEF, 1'b1};
      vec[3] = '{32'h0000_0110, 1'b1, 32'hDEAD_BEEF, 1'b0};
      vec[4] = '{32'h0000_0010, 1'b0, 32'h0000_0513, 1'b0};
      vec[5] = '{32'h0000_0014, 1'b0, 32'h1122_3344, 1'b0};
      vec[6] = '{32'h0000_0017, 1'b1, 32'h1122_3344, 1'b0};
      vec[7] = '{32'hFFFF_FFFC, 1'b0, 32'hCAFE_F00D, 1'b0};
      vec[8] = '{32'hFFFF_FFFE, 1'b1, 32'hCAFE_F00D, 1'b0};

      rst = 1'b1;
      bus.rob_rollback_in   = 1'b0;
      bus.fet_request_in    = 1'b0;
      bus.fet_address_in    = '0;
      bus.mc_ready_in       = 1'b0;
      bus.mc_instruction_in = '0;
      step(); step();
      rst = 1'b0;
      chk_reset_outputs();

      foreach (vec[i]) fetch(vec[i].addr, vec[i].hit, vec[i].data, vec[i].poke);

      // Stray refill while idle must not overwrite the last missed line.
      bus.mc_ready_in = 1'b1; bus.mc_instruction_in = 32'h0BAD_0BAD;
      step();
      bus.mc_ready_in = 1'b0;
      chk("stray_idle", bus.fet_ready_out, 0);
      step();
      fetch(32'hFFFF_FFFC, 1'b1, 32'hCAFE_F00D, 1'b0);

      // Rollback while waiting for refill; the late response is ignored.
      fetch_start(32'h20, 1'b0, 32'h0);
      bus.rob_rollback_in = 1'b1;
      step();
      bus.rob_rollback_in = 1'b0;
      chk("rb_miss_ready", bus.fet_ready_out, 0);
      bus.mc_ready_in = 1'b1; bus.mc_instruction_in = 32'h9999_9999;
      step();
      bus.mc_ready_in = 1'b0;
      chk("rb_late_fill", bus.fet_ready_out, 0);
      step();
      fetch(32'h20, 1'b0, 32'h2222_2222, 1'b0);

      // Rollback coincident with the refill response.
      fetch_start(32'h40, 1'b0, 32'h0);
      bus.rob_rollback_in = 1'b1;
      bus.mc_ready_in = 1'b1; bus.mc_instruction_in = 32'h4444_0000;
      step();
      bus.rob_rollback_in = 1'b0;
      bus.mc_ready_in = 1'b0;
      chk("rb_coinc_ready", bus.fet_ready_out, 0);
      step();
      fetch(32'h10, 1'b1, 32'h0000_0513, 1'b0);
      fetch(32'h40, 1'b0, 32'h4444_4444, 1'b0);

      // Request in the same cycle as rollback is dropped.
      bus.rob_rollback_in = 1'b1;
      bus.fet_request_in = 1'b1; bus.fet_address_in = 32'h10;
      step();
      bus.rob_rollback_in = 1'b0;
      bus.fet_request_in = 1'b0;
      chk("rb_drop_ready", bus.fet_ready_out, 0);
      chk("rb_drop_mcreq", bus.mc_request_out, 0);
      step();

      // Reset mid-miss, then a stray response; everything must miss afterwards.
      fetch_start(32'h80, 1'b0, 32'h0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_reset_outputs();
      bus.mc_ready_in = 1'b1; bus.mc_instruction_in = 32'h8888_8888;
      step();
      bus.mc_ready_in = 1'b0;
      chk("rst_stray_ready", bus.fet_ready_out, 0);
      step();
      fetch(32'h00, 1'b0, 32'h0000_0001, 1'b0);
      fetch(32'h10, 1'b0, 32'h0000_0513, 1'b0);
      fetch(32'h20, 1'b0, 32'h2222_0000, 1'b0);
      fetch(32'h20, 1'b1, 32'h2222_0000, 1'b0);

      step();
      chk("fet_q_empty", fet_q.size(), 0);
      chk("mc_q_empty", mc_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter INDEX_BITS, default 6, log2 of line count (64 direct-mapped lines, one 32-bit word per line).
REQ-002 Parameter TAG_BITS, default 30-INDEX_BITS, tag width taken from fetch address bits [31:INDEX_BITS+2].
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rob_rollback_in  input  1  pipeline flush; aborts any outstanding fetch.
REQ-006 fet_request_in  input  1  single-cycle fetch request pulse from fetcher.
REQ-007 fet_address_in  input  32  fetch byte address; bits [1:0] ignored.
REQ-008 fet_ready_out  output  1  single-cycle pulse, instruction valid.
REQ-009 fet_instruction_out  output  32  returned instruction, valid when fet_ready_out=1.
REQ-010 mc_request_out  output  1  single-cycle refill request pulse to memory controller.
REQ-011 mc_address_out  output  32  refill word address, bits [1:0] forced 0.
REQ-012 mc_ready_in  input  1  single-cycle pulse, refill word valid.
REQ-013 mc_instruction_in  input  32  refill word, little-endian as assembled by memory controller.

Function
REQ-014 Storage: per line valid bit, TAG_BITS tag, 32-bit data; index = addr[INDEX_BITS+1:2].
REQ-015 States: IDLE, MISS (refill requested, awaiting mc_ready_in).
REQ-016 IDLE + fet_request_in + hit (valid & tag match): fet_ready_out=1 and fet_instruction_out=line data on next cycle; remain IDLE.
REQ-017 IDLE + fet_request_in + miss: latch address; next cycle mc_request_out=1 for exactly one cycle with mc_address_out=latched address; go MISS.
REQ-018 MISS + mc_ready_in: write line valid=1, tag, data=mc_instruction_in; next cycle fet_ready_out=1, fet_instruction_out=mc_instruction_in; go IDLE.
REQ-019 Hit latency 1 cycle; miss latency = memory controller latency + 2 cycles (request issue cycle + response cycle).
REQ-020 fet_request_in while in MISS shall be ignored (fetcher keeps at most one request outstanding).
REQ-021 mc_ready_in while in IDLE shall be ignored; no line written, no fet_ready_out.
REQ-022 fet_ready_out and mc_request_out shall each be 0 in every cycle not explicitly stated above.
REQ-023 rob_rollback_in (any state): go IDLE; no fet_ready_out for the aborted request; fet_request_in same cycle dropped.
REQ-024 rob_rollback_in coincident with mc_ready_in: fill discarded, no line written, no fet_ready_out.
REQ-025 Rollback shall not clear valid bits; cached contents survive flushes.
REQ-026 fet_instruction_out and mc_address_out hold last value when their strobes are 0.
REQ-027 Self-modifying code not supported; no invalidate from stores.

Reset
REQ-028 rst: state=IDLE, all valid bits 0, fet_ready_out=0, fet_instruction_out=0, mc_request_out=0, mc_address_out=0.
REQ-029 rst has priority over rob_rollback_in and all requests; rst mid-MISS abandons refill, later mc_ready_in ignored.
REQ-030 Tag/data arrays need not be reset; only valid bits.

Verification
REQ-031 Cold miss: after rst, request 0x0000_0010 -> mc_request_out pulse next cycle with addr 0x10; mc_ready_in data 0x0000_0513 -> fet_ready_out next cycle with 0x0000_0513.
REQ-032 Hit: repeat request 0x10 -> fet_ready_out 1 cycle later with 0x0000_0513, no mc_request_out.
REQ-033 Conflict: request 0x110 (same index 4, INDEX_BITS=6), fill 0xDEAD_BEEF -> then 0x10 misses again, mc_request_out addr 0x10.
REQ-034 Rollback in MISS: miss on 0x20, assert rob_rollback_in before mc_ready_in -> no fet_ready_out; later request 0x20 misses (line not filled).
REQ-035 Rollback coincident with mc_ready_in -> no fet_ready_out, line stays invalid; rollback does not invalidate 0x10 (still hits).
REQ-036 Reset mid-MISS: rst during MISS, then stray mc_ready_in -> no fet_ready_out, all lines miss.
